npc_sweep_ctrl: RTL and testbench

//  Sequencer for the non-pivot cover analyzer. For each candidate spare solution (DSSS/RLSS

---
 rtl/npc_sweep_ctrl_pkg.sv | 33 +++
 rtl/npc_sweep_ctrl_valid_pipe.sv | 34 +++
 rtl/npc_sweep_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_npc_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/npc_sweep_ctrl_pkg.sv
// Shared constants for the non-pivot cover sweep sequencer and the fault-buffer writer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package npc_sweep_ctrl_pkg;

  // Fault buffer geometry and candidate index width
  localparam int NP_DEPTH   = 16;
  localparam int NP_AW      = $clog2(NP_DEPTH);
  localparam int SOL_W      = 5;

  // Cycles from NP* outputs changing to the matching cover_info edge
  localparam int COVER_LAT  = 1;

  // Fault entry layout: {row_addr, row_bnk, col_addr, col_bnk}
  localparam int NP_ENTRY_W   = 24;
  localparam int ADDR_W       = 10;
  localparam int BNK_W        = 2;
  localparam int COL_BNK_LSB  = 0;
  localparam int COL_ADDR_LSB = COL_BNK_LSB + BNK_W;
  localparam int ROW_BNK_LSB  = COL_ADDR_LSB + ADDR_W;
  localparam int ROW_ADDR_LSB = ROW_BNK_LSB + BNK_W;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SWEEP = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } sweep_state_e;

endpackage

// File: rtl/npc_sweep_ctrl_valid_pipe.sv
// Tracks which analyzer cycles carry a live non-pivot entry (DEPTH-stage valid shift register).
// Latency: a valid pushed on i_vld appears on o_tap DEPTH cycles later.
// Backpressure: none; i_flush discards everything in flight.
module npc_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_vld,
  output logic o_tap,
  output logic o_drained
);

  // Every stage except the tap; once these are clear the tap holds the final live entry
  localparam logic [DEPTH-1:0] LOWER_MASK = DEPTH'((64'd1 << (DEPTH - 1)) - 64'd1);

  logic [DEPTH-1:0] r_sr;

  // Shift issue strobes toward the tap, one stage per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_flush) begin
      r_sr <= '0;
    end else begin
      r_sr <= (r_sr << 1) | DEPTH'(i_vld);
    end
  end

  assign o_tap     = r_sr[DEPTH-1];
  assign o_drained = ((r_sr & LOWER_MASK) == '0);

endmodule

// File: rtl/npc_sweep_ctrl.sv
// Steps through candidate spare solutions, streaming every stored non-pivot into the analyzer.
// Latency: per candidate 1 (LOAD) + N + COVER_LAT cycles, +1 (NEXT) between candidates.
// Backpressure: none; one entry per SWEEP cycle, stops issuing at the first uncovered entry.
module npc_sweep_ctrl
  import npc_sweep_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SOL_W-1:0]      num_sol,
  input  logic [NP_AW:0]        np_count,
  output logic [NP_AW-1:0]      np_rd_addr,
  input  logic [NP_ENTRY_W-1:0] np_rd_data,
  output logic [SOL_W-1:0]      sol_idx,
  output logic [ADDR_W-1:0]     NPr_addr,
  output logic [BNK_W-1:0]      NPr_bnk,
  output logic [ADDR_W-1:0]     NPc_addr,
  output logic [BNK_W-1:0]      NPc_bnk,
  output logic                  np_valid,
  input  logic                  cover_info,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [SOL_W-1:0]      sol_found
);

  localparam logic [NP_AW:0]   CNT_ONE = (NP_AW + 1)'(1);
  localparam logic [NP_AW-1:0] IDX_ONE = NP_AW'(1);
  localparam logic [SOL_W-1:0] SOL_ONE = SOL_W'(1);

  sweep_state_e r_state;
  sweep_state_e w_next;

  logic [SOL_W-1:0]  r_num_sol;
  logic [SOL_W-1:0]  r_sol_idx;
  logic [SOL_W-1:0]  r_sol_found;
  logic [NP_AW:0]    r_np_count;
  logic [NP_AW-1:0]  r_idx;
  logic              r_fail;
  logic              r_busy;
  logic              r_found;
  logic              r_np_valid;
  logic [ADDR_W-1:0] r_npr_addr;
  logic [BNK_W-1:0]  r_npr_bnk;
  logic [ADDR_W-1:0] r_npc_addr;
  logic [BNK_W-1:0]  r_npc_bnk;

  logic w_accept;
  logic w_issue;
  logic w_win;
  logic w_tap;
  logic w_drained;
  logic w_miss;
  logic w_fail_now;
  logic w_last_idx;
  logic w_last_sol;
  logic w_flush;

  // A live entry the analyzer reports as uncovered disqualifies this candidate
  assign w_miss     = w_tap & ~cover_info;
  assign w_fail_now = r_fail | w_miss;
  assign w_last_idx = ({1'b0, r_idx} == (r_np_count - CNT_ONE));
  assign w_last_sol = (r_sol_idx == (r_num_sol - SOL_ONE));
  assign w_flush    = (r_state == ST_LOAD);

  npc_valid_pipe #(
    .DEPTH (COVER_LAT)
  ) u_vpipe (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (w_flush),
    .i_vld     (w_issue),
    .o_tap     (w_tap),
    .o_drained (w_drained)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle strobes
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_win    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (num_sol == '0) begin
            w_next = ST_FIN;
          end else begin
            w_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // With no non-pivots stored, the first candidate trivially covers them all
        if (r_np_count == '0) begin
          w_win  = 1'b1;
          w_next = ST_FIN;
        end else begin
          w_next = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (w_miss) begin
          w_next = ST_DRAIN;
        end else begin
          w_issue = 1'b1;
          if (w_last_idx) begin
            w_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_drained) begin
          if (!w_fail_now) begin
            w_win  = 1'b1;
            w_next = ST_FIN;
          end else if (w_last_sol) begin
            w_next = ST_FIN;
          end else begin
            w_next = ST_NEXT;
          end
        end
      end
      ST_NEXT: w_next = ST_LOAD;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Search bookkeeping: latched request, counters, fail flag and held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_sol   <= '0;
      r_np_count  <= '0;
      r_sol_idx   <= '0;
      r_sol_found <= '0;
      r_idx       <= '0;
      r_fail      <= 1'b0;
      r_busy      <= 1'b0;
      r_found     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num_sol   <= num_sol;
        r_np_count  <= np_count;
        r_sol_idx   <= '0;
        r_busy      <= 1'b1;
        r_found     <= 1'b0;
        r_sol_found <= '0;
      end
      if (r_state == ST_LOAD) begin
        r_idx  <= '0;
        r_fail <= 1'b0;
      end
      if (w_issue) begin
        r_idx <= r_idx + IDX_ONE;
      end
      if ((r_state == ST_SWEEP) || (r_state == ST_DRAIN)) begin
        r_fail <= w_fail_now;
      end
      if (w_win) begin
        r_found     <= 1'b1;
        r_sol_found <= r_sol_idx;
      end
      if (r_state == ST_NEXT) begin
        r_sol_idx <= r_sol_idx + SOL_ONE;
      end
      if (r_state == ST_FIN) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Registered entry toward the analyzer; fields hold their last value between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_np_valid <= 1'b0;
      r_npr_addr <= '0;
      r_npr_bnk  <= '0;
      r_npc_addr <= '0;
      r_npc_bnk  <= '0;
    end else begin
      r_np_valid <= w_issue;
      if (w_issue) begin
        r_npr_addr <= np_rd_data[ROW_ADDR_LSB +: ADDR_W];
        r_npr_bnk  <= np_rd_data[ROW_BNK_LSB  +: BNK_W];
        r_npc_addr <= np_rd_data[COL_ADDR_LSB +: ADDR_W];
        r_npc_bnk  <= np_rd_data[COL_BNK_LSB  +: BNK_W];
      end
    end
  end

  assign np_rd_addr = r_idx;
  assign sol_idx    = r_sol_idx;
  assign NPr_addr   = r_npr_addr;
  assign NPr_bnk    = r_npr_bnk;
  assign NPc_addr   = r_npc_addr;
  assign NPc_bnk    = r_npc_bnk;
  assign np_valid   = r_np_valid;
  assign busy       = r_busy;
  assign done       = (r_state == ST_FIN);
  assign found      = r_found;
  assign sol_found  = r_sol_found;

endmodule

// File: tb/tb_npc_sweep_ctrl.sv
// Bench for npc_sweep_ctrl: fault buffer and analyzer modelled as lookup tables.
// Expected results come from a candidate/entry-level model of the search rules.
// Directed cases first, then randomized searches, then a mid-sweep reset.
module tb_npc_sweep_ctrl;

  localparam int LAT = npc_sweep_ctrl_pkg::COVER_LAT;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  num_sol;
  logic [4:0]  np_count;
  logic [3:0]  np_rd_addr;
  logic [23:0] np_rd_data;
  logic [4:0]  sol_idx;
  logic [9:0]  NPr_addr;
  logic [1:0]  NPr_bnk;
  logic [9:0]  NPc_addr;
  logic [1:0]  NPc_bnk;
  logic        np_valid;
  logic        cover_info;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  sol_found;

  int checks = 0;
  int failures = 0;

  logic [23:0] fbuf [0:15];
  bit          cov  [0:31][0:15];
  logic        noise = 1'b0;
  logic [28:0] obs_q [$];
  int          done_cnt = 0;

  npc_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_sol    (num_sol),
    .np_count   (np_count),
    .np_rd_addr (np_rd_addr),
    .np_rd_data (np_rd_data),
    .sol_idx    (sol_idx),
    .NPr_addr   (NPr_addr),
    .NPr_bnk    (NPr_bnk),
    .NPc_addr   (NPc_addr),
    .NPc_bnk    (NPc_bnk),
    .np_valid   (np_valid),
    .cover_info (cover_info),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .sol_found  (sol_found)
  );

  always #5 clk = ~clk;

  // Combinational fault buffer; low 4 bits of each entry encode its own index
  assign np_rd_data = fbuf[np_rd_addr];
  // Analyzer: cover verdict for the entry on NP* under the current candidate, junk otherwise
  assign cover_info = np_valid ? cov[sol_idx][{NPc_addr[1:0], NPc_bnk}] : noise;

  always @(negedge clk) begin
    noise <= 1'($urandom);
    if (np_valid) obs_q.push_back({sol_idx, NPr_addr, NPr_bnk, NPc_addr, NPc_bnk});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({sol_idx, NPr_addr, NPr_bnk, NPc_addr, NPc_bnk, np_valid,
                busy, done, found, sol_found, np_rd_addr});
  endfunction

  task automatic fill_fbuf();
    for (int i = 0; i < 16; i++) fbuf[i] = {20'($urandom), 4'(i)};
  endtask

  task automatic set_cov(input int s, input logic [15:0] mask);
    for (int j = 0; j < 16; j++) cov[s][j] = mask[j];
  endtask

  // One search: model, drive, then compare result, latency and the issued entry stream
  task automatic run_search(input string tag, input int ns, input int nc, input int exp_lat,
                            input bit poke_mid, input bit poke_fin);
    logic [28:0] exp_q [$];
    int  base, dbase, lat, k, issued, last, bad;
    bit  got, ef;
    logic [4:0] esf;
    ef = 0; esf = '0; last = 0;
    for (int s = 0; s < ns; s++) begin
      last = s;
      k = nc;
      for (int j = nc - 1; j >= 0; j--) if (!cov[s][j]) k = j;
      issued = (k == nc) ? nc : ((k + LAT < nc) ? k + LAT : nc);
      for (int j = 0; j < issued; j++) exp_q.push_back({5'(s), fbuf[j]});
      if (k == nc) begin
        ef = 1; esf = 5'(s);
        break;
      end
    end

    @(negedge clk);
    base = obs_q.size();
    dbase = done_cnt;
    num_sol = 5'(ns);
    np_count = 5'(nc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 3000) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        start = poke_mid && (lat == 2);
        num_sol = 5'($urandom);
        np_count = 5'($urandom_range(0, 16));
        @(posedge clk);
        lat++;
      end
    end
    chk({tag, "/done_seen"}, 64'(got), 64'(1));
    if (exp_lat >= 0) chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/found"}, 64'(found), 64'(ef));
    chk({tag, "/sol_found"}, 64'(sol_found), 64'(esf));
    chk({tag, "/sol_idx_end"}, 64'(sol_idx), 64'(last));
    chk({tag, "/busy_in_fin"}, 64'(busy), 64'(1));
    start = poke_fin;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "/busy_after"}, 64'(busy), 64'(0));
    chk({tag, "/done_pulse"}, 64'(done_cnt - dbase), 64'(1));
    chk({tag, "/found_held"}, 64'({found, sol_found}), 64'({ef, esf}));
    chk({tag, "/issued"}, 64'(obs_q.size() - base), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= obs_q.size() || obs_q[base + i] !== exp_q[i]) bad++;
    chk({tag, "/stream"}, 64'(bad), 64'(0));
  endtask

  initial begin
    int ns, nc, dbase;
    bit hit;
    rst = 1'b0; start = 1'b0; num_sol = '0; np_count = '0;
    for (int s = 0; s < 32; s++) set_cov(s, 16'hFFFF);
    fill_fbuf();
    #2 rst = 1'b1;
    #2 chk("reset/outputs", all_outs(), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/held", all_outs(), 64'(0));
    rst = 1'b0;

    // 1: first candidate covers everything
    set_cov(0, 16'hFFFF); set_cov(1, 16'h0000); set_cov(2, 16'h0000);
    run_search("t1", 3, 4, 1 + 4 + LAT, 0, 0);

    // 2: cand0 misses entry 2, cand1 misses entry 0, cand2 covers
    set_cov(0, 16'hFFFB); set_cov(1, 16'hFFFE); set_cov(2, 16'hFFFF);
    run_search("t2", 3, 4, -1, 0, 0);

    // 3: both candidates miss their last entry -> not found
    set_cov(0, 16'hFFFB); set_cov(1, 16'hFFFB);
    run_search("t3", 2, 3, 2 * (1 + 3 + LAT) + 1, 0, 0);

    // 4: no non-pivots stored -> trivial cover by candidate 0
    set_cov(0, 16'h0000);
    run_search("t4", 4, 0, 1, 0, 0);

    // 5: no candidates, with start pulsed during FIN; then start pulsed mid-search
    run_search("t5", 0, 5, 0, 0, 1);
    set_cov(0, 16'hFFFB); set_cov(1, 16'hFFFE); set_cov(2, 16'hFFFF);
    run_search("t5b", 3, 4, -1, 1, 1);

    // Randomized searches
    for (int it = 0; it < 12; it++) begin
      fill_fbuf();
      ns = $urandom_range(0, 6);
      nc = $urandom_range(0, 16);
      for (int s = 0; s < 6; s++) begin
        if ($urandom_range(0, 2) == 0) set_cov(s, 16'hFFFF);
        else set_cov(s, 16'($urandom) | 16'($urandom) | 16'($urandom));
      end
      run_search($sformatf("rnd%0d", it), ns, nc, -1, it[0], it[1]);
    end

    // 6: reset while sweeping candidate 1
    fill_fbuf();
    set_cov(0, 16'hFFFE); set_cov(1, 16'hFFFF); set_cov(2, 16'hFFFF);
    @(negedge clk);
    num_sol = 5'd3; np_count = 5'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (sol_idx == 5'd1 && np_valid) hit = 1;
    end
    chk("t6/reached_cand1", 64'(hit), 64'(1));
    dbase = done_cnt;
    #2 rst = 1'b1;
    #1 chk("t6/outputs_cleared", all_outs(), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6/held_in_reset", all_outs(), 64'(0));
    chk("t6/no_done", 64'(done_cnt - dbase), 64'(0));
    rst = 1'b0;
    run_search("t6_after", 3, 8, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
